gpi_input_conditioner: RTL and testbench

Per-bit input conditioner for raw board inputs such as switches and push-buttons. It sits directly upstream of the general-purpose input MMIO core and drives that core's din bus.
- Synchronises each asynchronous bit into clk.
- Debounces each bit with a shared-prescaler stability counter.
- Emits one-cycle rise/fall event pulses for edge-sensitive consumers.

---
 rtl/gpi_cond_pkg.sv | 12 +
 rtl/debounce_bit.sv | 51 +++++
 rtl/gpi_input_conditioner.sv | 45 ++++
 tb/tb_gpi_input_conditioner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/gpi_cond_pkg.sv
// gpi_cond_pkg: shared defaults and counter-width helper for the GPI input conditioner.
package gpi_cond_pkg;

    localparam int DEF_TICK_DIV     = 100000;
    localparam int DEF_STABLE_TICKS = 20;

    // A counter for 0..n-1 still needs one bit when n is 1.
    function automatic int cnt_width(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: one-bit 2-FF synchroniser, tick-qualified stability counter and rise/fall event registers.
module debounce_bit
    import gpi_cond_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic reset,
    input  logic din_raw,
    input  logic tick,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int CW = cnt_width(STABLE_TICKS);
    localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

    logic          s1;
    logic          sync;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          differ;
    logic          accept;

    // Any sample agreeing with db restarts qualification, tick or not.
    always_comb begin
        differ  = sync != db;
        accept  = differ & tick & (cnt == LAST);
        cnt_nxt = !differ ? '0 : !tick ? cnt : accept ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            sync <= 1'b0;
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= din_raw;
            sync <= s1;
            cnt  <= cnt_nxt;
            db   <= accept ? sync : db;
            rise <= accept & sync;
            fall <= accept & ~sync;
        end
    end

endmodule

// File: rtl/gpi_input_conditioner.sv
// gpi_input_conditioner: per-bit synchronise/debounce of raw board inputs with rise/fall event pulses.
module gpi_input_conditioner
    import gpi_cond_pkg::*;
#(
    parameter int W            = 8,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din_raw,
    output logic [W-1:0] db_out,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    localparam int PW = cnt_width(TICK_DIV);
    localparam logic [PW-1:0] PLAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pcnt;
    logic          tick;

    // One free-running prescaler paces every bit, so simultaneous changes share ticks.
    assign tick = pcnt == PLAST;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pcnt <= '0;
        else       pcnt <= tick ? '0 : pcnt + 1'b1;
    end

    for (genvar i = 0; i < W; i++) begin : g_bit
        debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_db (
            .clk    (clk),
            .reset  (reset),
            .din_raw(din_raw[i]),
            .tick   (tick),
            .db     (db_out[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

endmodule

// File: tb/tb_gpi_input_conditioner.sv
// tb_gpi_input_conditioner: random/directed stimulus against a tick-counting reference model for two parameter sets.
module tb_gpi_input_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din_raw = 8'hFF;
    logic [7:0] db0, rise0, fall0, db1, rise1, fall1;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gpi_input_conditioner #(.W(8), .TICK_DIV(4), .STABLE_TICKS(3)) dut0 (
        .clk(clk), .reset(reset), .din_raw(din_raw), .db_out(db0), .rise(rise0), .fall(fall0));

    gpi_input_conditioner #(.W(8), .TICK_DIV(1), .STABLE_TICKS(1)) dut1 (
        .clk(clk), .reset(reset), .din_raw(din_raw), .db_out(db1), .rise(rise1), .fall(fall1));

    // Model: edge e (counted from reset release) is a tick when e mod D == D-1; the pin value
    // driven before edge e-2 is what the debouncer sees at edge e; a new level is accepted on the
    // tick where the number of ticks since disagreement began reaches S.
    int         dv[2] = '{4, 1};
    int         sv[2] = '{3, 1};
    int         e;
    logic [7:0] hist[$];
    logic [7:0] db_m[2], rise_m[2], fall_m[2];
    int         start[2][8];

    task automatic model_clear();
        e = 0;
        hist.delete();
        for (int k = 0; k < 2; k++) begin
            db_m[k] = '0; rise_m[k] = '0; fall_m[k] = '0;
            for (int b = 0; b < 8; b++) start[k][b] = -1;
        end
    endtask

    task automatic model_edge();
        logic sb;
        hist.push_back(din_raw);
        for (int k = 0; k < 2; k++) begin
            rise_m[k] = '0;
            fall_m[k] = '0;
            for (int b = 0; b < 8; b++) begin
                sb = (e >= 2) ? hist[e-2][b] : 1'b0;
                if (sb == db_m[k][b]) start[k][b] = -1;
                else begin
                    if (start[k][b] < 0) start[k][b] = e;
                    if ((e % dv[k]) == dv[k] - 1 &&
                        ((e + 1) / dv[k] - start[k][b] / dv[k]) >= sv[k]) begin
                        db_m[k][b]   = sb;
                        rise_m[k][b] = sb;
                        fall_m[k][b] = ~sb;
                        start[k][b]  = -1;
                    end
                end
            end
        end
        e++;
    endtask

    task automatic check(input string tag);
        vectors++;
        assert ({db0, rise0, fall0} === {db_m[0], rise_m[0], fall_m[0]}) else begin
            miscompares++;
            $error("FAIL %s dut0: got db=%h rise=%h fall=%h expected db=%h rise=%h fall=%h",
                   tag, db0, rise0, fall0, db_m[0], rise_m[0], fall_m[0]);
        end
        vectors++;
        assert ({db1, rise1, fall1} === {db_m[1], rise_m[1], fall_m[1]}) else begin
            miscompares++;
            $error("FAIL %s dut1: got db=%h rise=%h fall=%h expected db=%h rise=%h fall=%h",
                   tag, db1, rise1, fall1, db_m[1], rise_m[1], fall_m[1]);
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check(tag);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        model_clear();
        check("reset_assert");
        repeat (n) begin
            @(posedge clk);
            #1;
            check("reset_hold");
        end
        reset = 1'b0;
    endtask

    task automatic measure(input int k, input logic [7:0] mask, input logic [7:0] want,
                           input string tag, output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            step(tag);
            if ((((k == 0) ? db0 : db1) & mask) == want) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_range(input string tag, input int n, input int lo, input int hi);
        vectors++;
        assert (n >= lo && n <= hi) else begin
            miscompares++;
            $error("FAIL %s: got %0d edges expected %0d..%0d", tag, n, lo, hi);
        end
    endtask

    initial begin
        int n;
        // Inputs high through reset; db_out must qualify them from scratch.
        do_reset(2);
        measure(0, 8'hFF, 8'hFF, "reset_release", n);
        check_range("reset_release_latency", n, 11, 14);
        vectors++;
        assert (rise0 === 8'hFF) else begin
            miscompares++;
            $error("FAIL reset_release_rise: got %h expected ff", rise0);
        end
        step("after_release");
        din_raw = 8'h00;
        repeat (20) step("all_low");

        din_raw = 8'h01;
        measure(0, 8'h01, 8'h01, "clean_step", n);
        check_range("clean_step_latency", n, 11, 14);
        repeat (4) step("clean_hold");

        din_raw = 8'h05;
        repeat (6) step("glitch_high");
        din_raw = 8'h01;
        repeat (20) step("glitch_low");
        vectors++;
        assert (db0[2] === 1'b0) else begin
            miscompares++;
            $error("FAIL glitch_reject: got db[2]=%b expected 0", db0[2]);
        end

        din_raw = 8'h05;
        repeat (10) step("dip_pre");
        din_raw = 8'h01;
        step("dip");
        din_raw = 8'h05;
        measure(0, 8'h04, 8'h04, "dip_requalify", n);
        check_range("dip_requalify_latency", n, 11, 14);

        din_raw = 8'h2D;
        repeat (20) step("bits35_high");
        din_raw = 8'h05;
        n = 99;
        for (int i = 1; i <= 30; i++) begin
            step("bits35_drop");
            if (fall0 != 8'h00) begin
                n = i;
                break;
            end
        end
        vectors++;
        assert (fall0 === 8'h28 && (db0 & 8'h28) === 8'h00 && n != 99) else begin
            miscompares++;
            $error("FAIL common_fall: got fall=%h db=%h after %0d expected fall=28 db&28=00",
                   fall0, db0, n);
        end

        din_raw = 8'h85;
        repeat (8) step("bit7_pre_reset");
        do_reset(2);
        measure(0, 8'h80, 8'h80, "bit7_after_reset", n);
        check_range("bit7_after_reset_latency", n, 11, 14);
        repeat (5) step("settle");

        din_raw = 8'h87;
        measure(1, 8'h02, 8'h02, "degenerate_step", n);
        check_range("degenerate_latency", n, 3, 3);
        vectors++;
        assert (rise1 === 8'h02) else begin
            miscompares++;
            $error("FAIL degenerate_rise: got %h expected 02", rise1);
        end

        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 5) == 0) din_raw = din_raw ^ (8'h01 << $urandom_range(0, 7));
            if (i == 450) do_reset($urandom_range(1, 3));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
